// File: rtl/vme_regbank_n.sv
`default_nettype none
// ============================================================================
// Module   : vme_regbank_n
// Purpose  : Parametrised VME-side register bank. NREGS read/write registers
//            behind the VME memory-strobe handshake, with address decode,
//            unmapped-address error flags, per-register write pulses and a
//            pipelined write path taking one request per cycle.
// Revision : 1.0  initial release
// ============================================================================
module vme_regbank_n #(
  parameter int                DATA_W  = 32,
  parameter int                NREGS   = 4,
  parameter int                ADDR_W  = 4,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [ADDR_W-1:0]       VMEAddr,
  input  logic [DATA_W-1:0]       VMEWrData,
  input  logic                    VMEWrMem,
  input  logic                    VMERdMem,
  output logic [DATA_W-1:0]       VMERdData,
  output logic                    VMERdDone,
  output logic                    VMEWrDone,
  output logic                    VMERdErr,
  output logic                    VMEWrErr,
  output logic [NREGS*DATA_W-1:0] regs_o,
  output logic [NREGS-1:0]        wr_pulse_o
);

  // Write request captured in the strobe cycle (stage 0 -> stage 1)
  logic              d0_valid;
  logic [ADDR_W-1:0] d0_addr;
  logic [DATA_W-1:0] d0_data;

  // Register storage
  logic [DATA_W-1:0] regs [NREGS];

  // Stage-1 write decode: one-hot register select, empty when unmapped
  logic [NREGS-1:0]  wr_sel;
  logic              wr_hit;

  // Read decode against the current register contents
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;

  // Capture the write strobe, address and data into the stage-0 register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      d0_valid <= 1'b0;
      d0_addr  <= '0;
      d0_data  <= '0;
    end else begin
      d0_valid <= VMEWrMem;
      if (VMEWrMem) begin
        d0_addr <= VMEAddr;
        d0_data <= VMEWrData;
      end
    end
  end

  // Full address compare per register, so upper address bits never alias
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_sel[i] = d0_valid && (d0_addr == ADDR_W'(i));
    end
  end

  assign wr_hit = |wr_sel;

  // Commit the decoded write at the end of stage 1
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= d0_data;
        end
      end
    end
  end

  // Stage 2: write acknowledge, error and per-register pulse
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      VMEWrDone  <= 1'b0;
      VMEWrErr   <= 1'b0;
      wr_pulse_o <= '0;
    end else begin
      VMEWrDone  <= d0_valid;
      VMEWrErr   <= d0_valid && !wr_hit;
      wr_pulse_o <= wr_sel;
    end
  end

  // Read mux; unmapped addresses return zero and flag a miss
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (VMEAddr == ADDR_W'(i)) begin
        rd_data = regs[i];
        rd_hit  = 1'b1;
      end
    end
  end

  // Read acknowledge; data holds until the next read is acknowledged
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      VMERdDone <= 1'b0;
      VMERdErr  <= 1'b0;
      VMERdData <= '0;
    end else begin
      VMERdDone <= VMERdMem;
      VMERdErr  <= VMERdMem && !rd_hit;
      if (VMERdMem) begin
        VMERdData <= rd_data;
      end
    end
  end

  // Flatten the register array onto the user-side bus
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs_o
      assign regs_o[gi*DATA_W +: DATA_W] = regs[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vme_regbank_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_vme_regbank_n
// Purpose  : Self-checking bench for vme_regbank_n: directed scenarios followed
//            by randomized traffic, compared against a cycle-indexed model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vme_regbank_n;

  localparam int          DW   = 32;
  localparam int          NR   = 4;
  localparam int          AW   = 4;
  localparam logic [31:0] RV   = 32'hC0DE_0001;
  localparam int          MAXC = 2048;

  logic           Clk;
  logic           Rst;
  logic [AW-1:0]  VMEAddr;
  logic [DW-1:0]  VMEWrData;
  logic           VMEWrMem;
  logic           VMERdMem;
  logic [DW-1:0]  VMERdData;
  logic           VMERdDone;
  logic           VMEWrDone;
  logic           VMERdErr;
  logic           VMEWrErr;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0]  wr_pulse_o;

  vme_regbank_n #(
    .DATA_W (DW),
    .NREGS  (NR),
    .ADDR_W (AW),
    .RST_VAL(RV)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .VMEAddr   (VMEAddr),
    .VMEWrData (VMEWrData),
    .VMEWrMem  (VMEWrMem),
    .VMERdMem  (VMERdMem),
    .VMERdData (VMERdData),
    .VMERdDone (VMERdDone),
    .VMEWrDone (VMEWrDone),
    .VMERdErr  (VMERdErr),
    .VMEWrErr  (VMEWrErr),
    .regs_o    (regs_o),
    .wr_pulse_o(wr_pulse_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Request history indexed by issue cycle, plus the reference register file
  logic        wv_h [MAXC];
  logic [3:0]  wa_h [MAXC];
  logic [31:0] wd_h [MAXC];
  logic        rv_h [MAXC];
  logic [31:0] rexp_d [MAXC];
  logic        rexp_e [MAXC];
  logic [31:0] mdl [NR];
  logic [31:0] lastrd;
  int          c;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check all outputs
  task automatic cycle(input bit rst_i, input bit wv, input bit rv,
                       input logic [3:0] a, input logic [31:0] d);
    logic [3:0]  pa;
    logic [NR-1:0] exp_pulse;
    logic        exp_wd, exp_we, exp_rd, exp_re;
    @(posedge Clk);
    #1;
    Rst       = rst_i;
    VMEWrMem  = wv & ~rst_i;
    VMERdMem  = rv & ~rst_i;
    VMEAddr   = a;
    VMEWrData = d;

    // A write issued two cycles ago has committed and is visible now
    if (wv_h[c-2] && wa_h[c-2] < 4'(NR)) mdl[wa_h[c-2]] = wd_h[c-2];

    if (rst_i) begin
      wv_h[c-2] = 1'b0;
      wv_h[c-1] = 1'b0;
      rv_h[c-1] = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = RV;
      lastrd = '0;
    end

    wv_h[c]   = VMEWrMem;
    wa_h[c]   = a;
    wd_h[c]   = d;
    rv_h[c]   = VMERdMem;
    rexp_d[c] = (a < 4'(NR)) ? mdl[a] : 32'h0;
    rexp_e[c] = (a >= 4'(NR));

    @(negedge Clk);
    pa        = wa_h[c-2];
    exp_wd    = wv_h[c-2];
    exp_we    = wv_h[c-2] && (pa >= 4'(NR));
    exp_pulse = (wv_h[c-2] && pa < 4'(NR)) ? NR'(1 << pa) : '0;
    exp_rd    = rv_h[c-1];
    exp_re    = rv_h[c-1] && rexp_e[c-1];
    if (rv_h[c-1]) lastrd = rexp_d[c-1];

    chk("wr_done",  128'(VMEWrDone),  128'(exp_wd));
    chk("wr_err",   128'(VMEWrErr),   128'(exp_we));
    chk("wr_pulse", 128'(wr_pulse_o), 128'(exp_pulse));
    chk("regs",     128'(regs_o),     {mdl[3], mdl[2], mdl[1], mdl[0]});
    chk("rd_done",  128'(VMERdDone),  128'(exp_rd));
    chk("rd_err",   128'(VMERdErr),   128'(exp_re));
    chk("rd_data",  128'(VMERdData),  128'(lastrd));
    c++;
  endtask

  initial begin
    logic [3:0] ra;
    errors    = 0;
    checks    = 0;
    c         = 2;
    lastrd    = '0;
    Rst       = 1'b1;
    VMEWrMem  = 1'b0;
    VMERdMem  = 1'b0;
    VMEAddr   = '0;
    VMEWrData = '0;
    for (int i = 0; i < MAXC; i++) begin
      wv_h[i] = 1'b0; wa_h[i] = '0; wd_h[i] = '0;
      rv_h[i] = 1'b0; rexp_d[i] = '0; rexp_e[i] = 1'b0;
    end
    for (int i = 0; i < NR; i++) mdl[i] = RV;

    // Reset held, then released
    cycle(1, 0, 0, 4'd0, 32'h0);
    cycle(1, 0, 0, 4'd0, 32'h0);

    // Write then read back addr 2
    cycle(0, 1, 0, 4'd2, 32'hDEADBEEF);
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 1, 4'd2, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);

    // Unmapped write and read
    cycle(0, 1, 0, 4'd5, 32'h12345678);
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 1, 4'd5, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);

    // Back-to-back writes to every register
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 4'(i), 32'(i + 1));
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);

    // Collision: simultaneous read and write on addr 1
    cycle(0, 1, 0, 4'd1, 32'hA);
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 1, 1, 4'd1, 32'hB);
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 1, 4'd1, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);

    // Hazard: reads one and two cycles after a write
    cycle(0, 1, 0, 4'd3, 32'h55);
    cycle(0, 0, 1, 4'd3, 32'h0);
    cycle(0, 0, 1, 4'd3, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);

    // Reset arriving the cycle after a write strobe
    cycle(0, 1, 1, 4'd0, 32'h99);
    cycle(1, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 1, 4'd0, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);

    // Randomized mixed traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                        : 4'($urandom_range(0, 3));
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ra, $urandom);
    end
    cycle(0, 0, 0, 4'd0, 32'h0);
    cycle(0, 0, 0, 4'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vme_regbank_n.md
# vme_regbank_n

Parametrised VME-side register bank: NREGS read/write registers of DATA_W bits, selected by a word address, behind the VME memory-strobe handshake (VMERdMem/VMEWrMem in, VMERdDone/VMEWrDone out). Successor to the single-register bank. Adds address decode, unmapped-address error reporting, per-register write pulses and a fully pipelined write path accepting one request per cycle. Sits between the VME slave decoder and the user logic of a subsystem.

## Interface
Parameters:
- DATA_W, 32, register and data-bus width (1..64)
- NREGS, 4, number of implemented registers (1..2**ADDR_W)
- ADDR_W, 4, width of the word address
- RST_VAL, 0, reset value of every register (DATA_W bits)

Ports:
- Clk  in  1  single clock; all logic rising-edge
- Rst  in  1  asynchronous, active-high reset
- VMEAddr  in  ADDR_W  word address, valid with a strobe
- VMEWrData  in  DATA_W  write data, valid with VMEWrMem
- VMEWrMem  in  1  one-cycle write strobe
- VMERdMem  in  1  one-cycle read strobe
- VMERdData  out  DATA_W  registered read data, valid while VMERdDone=1
- VMERdDone  out  1  one-cycle read acknowledge
- VMEWrDone  out  1  one-cycle write acknowledge
- VMERdErr  out  1  with VMERdDone: address >= NREGS
- VMEWrErr  out  1  with VMEWrDone: address >= NREGS
- regs_o  out  NREGS*DATA_W  register i on bits [i*DATA_W +: DATA_W]
- wr_pulse_o  out  NREGS  bit i high one cycle when register i was written

## Operation
- Reset (Rst=1, asynchronous): all registers = RST_VAL; VMERdData=0; VMERdDone, VMEWrDone, VMERdErr, VMEWrErr, wr_pulse_o all 0; all pipeline stages cleared. In-flight requests are dropped; no acknowledge is ever issued for them.
- Write path, 3 stages, no stall:
  - Stage 0 (strobe cycle): VMEWrMem, VMEAddr, VMEWrData registered into d0.
  - Stage 1: d0 decoded. Address < NREGS: register[addr] <= data at end of cycle. Otherwise: no register changes.
  - Stage 2: VMEWrDone=1; VMEWrErr=1 iff unmapped; wr_pulse_o[addr]=1 iff mapped; regs_o already shows the new value.
- Read path, 2 stages:
  - Stage 0: VMEAddr decoded combinationally against the current register contents.
  - Stage 1: VMERdDone=1. VMERdData = register[addr], or 0 with VMERdErr=1 if unmapped.
  - VMERdData holds its value until the next read acknowledge.
- Throughput: one write and/or one read accepted per cycle. Back-to-back strobes give back-to-back acknowledges, in issue order.
- Simultaneous VMERdMem and VMEWrMem (same address):
  - Both are accepted and both acknowledged.
  - The read returns the pre-write value.
  - VMEAddr applies to both.
- Read issued one cycle after a write to the same address returns the old value (the write commits at end of stage 1). A read two or more cycles after returns the new value.
- Address bits above log2(NREGS) are fully decoded (no aliasing).

## Timing
- Write latency: strobe in cycle N, VMEWrDone in cycle N+2. Register value visible on regs_o in N+2.
- Read latency: strobe in cycle N, VMERdDone and VMERdData in cycle N+1.
- All outputs registered. The only combinational input-to-register path is the read decode.
- Rst deassertion: first strobe accepted on the first rising edge with Rst=0.

## Test plan
- Reset: assert Rst mid-write (strobe at N, Rst at N+1). Required: VMEWrDone never asserts; register = RST_VAL; all outputs 0.
- Write/read: write 0xDEADBEEF to addr 2 at cycle N. Required:
  - VMEWrDone=1 and wr_pulse_o=4'b0100 at N+2; regs_o[95:64]=0xDEADBEEF.
  - Read addr 2 at N+3 gives VMERdDone at N+4 with 0xDEADBEEF, VMERdErr=0.
- Unmapped: write 0x12345678 to addr 5 (NREGS=4). Required: VMEWrDone+VMEWrErr at N+2; wr_pulse_o=0; regs unchanged. Read addr 5 gives VMERdData=0 with VMERdErr=1.
- Back-to-back: writes to addr 0,1,2,3 on four consecutive cycles with data 1,2,3,4. Required: four consecutive VMEWrDone pulses, wr_pulse_o walking 0001→1000, final regs 1,2,3,4.
- Collision: addr 1 holds 0xA; simultaneous read+write of 0xB to addr 1. Required: read returns 0xA at N+1; write acknowledged at N+2; a subsequent read returns 0xB.
- Hazard: write 0x55 to addr 3 at N, read addr 3 at N+1, and again at N+2. Required: reads return the old value and 0x55 respectively.
